// File: rtl/hrm_pkg.sv
// Shared HRM CPU definitions: opcode nibbles, default halt opcode, fetch FSM
// states and the two-byte instruction test used by fetch and control.
package hrm_pkg;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPP    = 4'h6;
  localparam logic [3:0] OP_BUMPN    = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [7:0] HALT_OP_DFLT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OP,
    LATCH_OP,
    WAIT_ARG,
    LATCH_ARG,
    READY,
    HALT
  } fetch_state_e;

  // Every instruction from COPYFROM through JUMPN carries an operand byte.
  function automatic logic has_arg_f(input logic [7:0] op);
    return (op[7:4] >= OP_COPYFROM) && (op[7:4] <= OP_JUMPN);
  endfunction

endpackage

// File: rtl/ifetch_decode.sv
// Combinational opcode classifier shared by fetch and control.
// The is_illegal output is live only when ILLEGAL_TRAP_EN is defined.
module ifetch_decode
  import hrm_pkg::*;
#(
  parameter logic [7:0] HALT_OP = HALT_OP_DFLT
) (
  input  logic [7:0] op,
  output logic       has_arg,
  output logic       is_halt,
  output logic       is_illegal
);

  assign has_arg = has_arg_f(op);
  assign is_halt = (op == HALT_OP);

`ifdef ILLEGAL_TRAP_EN
  // B..E are unassigned; any F-nibble byte other than the real halt is a trap.
  assign is_illegal = ((op[7:4] >= 4'hB) && (op[7:4] <= 4'hE)) ||
                      ((op[7:4] == OP_HALT) && (op != HALT_OP));
`else
  assign is_illegal = 1'b0;
`endif

endmodule

// File: rtl/ifetch.sv
// HRM instruction fetch stage: reads opcode and optional operand from the
// synchronous program ROM. Optional trap on illegal opcodes: ILLEGAL_TRAP_EN.
module ifetch
  import hrm_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] HALT_OP = HALT_OP_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              fetch_start,
  output logic              pc_inc,
  output logic [7:0]        ir,
  output logic [7:0]        arg,
  output logic              has_arg,
  output logic              instr_valid,
  output logic              halted,
  output logic              illegal
);

  fetch_state_e state_q, state_d;
  logic [7:0]   ir_q, ir_d;
  logic [7:0]   arg_q, arg_d;
  logic         has_arg_q, has_arg_d;
  logic         halted_q, halted_d;
  logic         dec_has_arg, dec_is_halt, dec_is_illegal;
`ifdef ILLEGAL_TRAP_EN
  logic         illegal_q, illegal_d;
`endif

  ifetch_decode #(.HALT_OP(HALT_OP)) u_decode (
    .op         (mem_data),
    .has_arg    (dec_has_arg),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    arg_d     = arg_q;
    has_arg_d = has_arg_q;
    halted_d  = halted_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    pc_inc    = 1'b0;
    unique case (state_q)
      IDLE:     if (fetch_start) state_d = WAIT_OP;
      WAIT_OP:  state_d = LATCH_OP;
      LATCH_OP: begin
        ir_d      = mem_data;
        has_arg_d = dec_has_arg;
        // Halting without pc_inc leaves PC parked on the offending byte.
        if (dec_is_halt || dec_is_illegal) begin
          halted_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          illegal_d = dec_is_illegal;
`endif
          state_d  = HALT;
        end else begin
          pc_inc  = 1'b1;
          state_d = dec_has_arg ? WAIT_ARG : READY;
        end
      end
      WAIT_ARG: state_d = LATCH_ARG;
      LATCH_ARG: begin
        arg_d   = mem_data;
        pc_inc  = 1'b1;
        state_d = READY;
      end
      READY:    if (fetch_start) state_d = WAIT_OP;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
    // PC must not step while the stage is being reset.
    if (rst) pc_inc = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ir_q      <= 8'h00;
      arg_q     <= 8'h00;
      has_arg_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      arg_q     <= arg_d;
      has_arg_q <= has_arg_d;
      halted_q  <= halted_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign mem_addr    = pc;
  assign ir          = ir_q;
  assign arg         = arg_q;
  assign has_arg     = has_arg_q;
  assign halted      = halted_q;
  assign instr_valid = (state_q == READY);

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage that sits directly downstream of the program counter in the HRM CPU.
- Reads the program ROM at the current PC and latches the opcode byte, plus the operand byte when the instruction has one.
- Pulses a PC-increment request after each byte it consumes.
- Presents the decoded instruction (ir, arg) to the control unit; arg also feeds the PC jump-address input.

Parameters:
- ADDR_W, 8, width of PC and program ROM address.
- HALT_OP, 8'hFF, opcode value that stops fetching.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc  in  ADDR_W  current PC value
- mem_addr  out  ADDR_W  program ROM address; combinationally equal to pc
- mem_data  in  8  ROM read data; synchronous ROM, valid the cycle after mem_addr
- fetch_start  in  1  control requests the next instruction
- pc_inc  out  1  one-cycle pulse; control ORs this into the PC write enable (increment path)
- ir  out  8  latched opcode byte
- arg  out  8  latched operand byte; drives the PC jump address
- has_arg  out  1  ir is a two-byte instruction
- instr_valid  out  1  ir/arg are stable and complete
- halted  out  1  HALT_OP fetched; sticky until rst
- illegal  out  1  only with ILLEGAL_TRAP_EN; otherwise tied 0

Behaviour:
- Reset state: IDLE. ir=0, arg=0, has_arg=0, instr_valid=0, halted=0, illegal=0, pc_inc=0.
- Reset has priority in every state; rst asserted mid-fetch aborts the fetch and returns to IDLE next edge.
- Opcode encoding:
  - ir[7:4]: 0 INBOX, 1 OUTBOX, 2 COPYFROM, 3 COPYTO, 4 ADD, 5 SUB, 6 BUMPP, 7 BUMPN, 8 JUMP, 9 JUMPZ, A JUMPN, F HALT.
  - ir[3] is the indirect flag.
  - Two-byte instructions are those with ir[7:4] in 2..A.
- IDLE: all outputs hold. On fetch_start, go to WAIT_OP.
- WAIT_OP: ROM latency cycle; go to LATCH_OP.
- LATCH_OP:
  - ir<=mem_data; has_arg<=two-byte test on mem_data; pc_inc=1 for this cycle.
  - If mem_data==HALT_OP: halted<=1, go to HALT; pc_inc is NOT asserted, so PC stays pointing at the HALT instruction.
  - Otherwise go to WAIT_ARG if two-byte, else READY.
- WAIT_ARG: PC has already incremented, so the ROM is now addressing the operand; go to LATCH_ARG.
- LATCH_ARG: arg<=mem_data; pc_inc=1; go to READY.
- READY:
  - instr_valid=1.
  - fetch_start moves directly to WAIT_OP, clearing instr_valid (back-to-back fetch).
  - A jump loaded into PC by control while in READY is simply picked up on the next fetch_start; no flush is needed.
- HALT: absorbing; instr_valid=0; fetch_start ignored; only rst exits.
- One-byte instructions leave arg at its previous value.
- Latency from fetch_start sampled in IDLE/READY to instr_valid: 3 cycles (one-byte), 5 cycles (two-byte).
- At most one pc_inc per byte. PC wrap 8'hFF->8'h00 is handled by PC; ifetch does nothing special.
- fetch_start outside IDLE/READY is ignored.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: in LATCH_OP, mem_data[7:4] in B..E, or (mem_data[7:4]==F and mem_data!=HALT_OP), sets illegal<=1 and halted<=1, goes to HALT, no pc_inc. illegal is sticky until rst.
- Undefined: such opcodes are treated as one-byte instructions and reach READY; illegal is constant 0.

Decomposition:
- Package hrm_pkg holds:
  - opcode nibble constants (OP_INBOX..OP_JUMPN, OP_HALT);
  - HALT_OP default;
  - the fetch state encoding (IDLE, WAIT_OP, LATCH_OP, WAIT_ARG, LATCH_ARG, READY, HALT);
  - a has_arg function.
- One natural sub-module: ifetch_decode, combinational, opcode to has_arg / is_halt / is_illegal, reusable by the control unit.

Test Plan:
- ROM[0]=8'h00 (INBOX), fetch_start at cycle 0 -> pc_inc high in cycle 2 only; instr_valid=1 in cycle 3; ir=8'h00; has_arg=0.
- ROM[4]=8'h20, ROM[5]=8'h07 (COPYFROM 7), pc=4 -> pc_inc in cycles 2 and 4; ir=8'h20, arg=8'h07, has_arg=1; instr_valid at cycle 5; PC ends at 6.
- ROM[1]=8'h80, ROM[2]=8'h0A, then control loads PC=10 with ROM[10]=8'h10; fetch_start issued in READY -> immediate new fetch; ir=8'h10 three cycles later.
- ROM[3]=8'hFF -> halted=1, no pc_inc, PC stays 3; later fetch_start pulses give no change; rst clears halted and instr_valid.
- rst asserted in WAIT_ARG -> IDLE next cycle; all outputs at reset values; no further pc_inc.
- ILLEGAL_TRAP_EN defined, ROM[0]=8'hC0 -> illegal=1, halted=1. Macro undefined, same ROM -> instr_valid=1, illegal=0.
